// File: rtl/ncl_dual_rail_rx.sv
// Clocked receiver for a dual-rail NCL word. It synchronises the rails, detects
// DATA/NULL completeness, drives the upstream acknowledge and presents each word on a valid/ready port.
module ncl_dual_rail_rx #(
    parameter int DIGITS      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic [DIGITS-1:0] rail1,
    input  logic [DIGITS-1:0] rail0,
    output logic              ack,
    output logic [DIGITS-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  word_count
);

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0][DIGITS-1:0] sync1;
    logic [SYNC_STAGES-1:0][DIGITS-1:0] sync0;
    logic [DIGITS-1:0] s1;
    logic [DIGITS-1:0] s0;
    logic all_data;
    logic all_null;
    logic any_illegal;
    logic slot_free;

    assign s1 = sync1[SYNC_STAGES-1];
    assign s0 = sync0[SYNC_STAGES-1];

    // An illegal digit (both rails high) fails both completeness tests.
    assign all_data    = &(s1 ^ s0);
    assign all_null    = ~|(s1 | s0);
    assign any_illegal = |(s1 & s0);
    assign slot_free   = ~word_valid | word_ready;

    always_ff @(posedge clk) begin
        if (!init_n) begin
            sync1       <= '0;
            sync0       <= '0;
            state       <= WAIT_DATA;
            ack         <= 1'b0;
            word        <= '0;
            word_valid  <= 1'b0;
            err_illegal <= 1'b0;
            word_count  <= '0;
        end else begin
            sync1 <= {sync1[SYNC_STAGES-2:0], rail1};
            sync0 <= {sync0[SYNC_STAGES-2:0], rail0};

            if (any_illegal)
                err_illegal <= 1'b1;

            // A capture in this cycle overrides the consume below.
            if (word_valid && word_ready)
                word_valid <= 1'b0;

            case (state)
                WAIT_DATA: begin
                    if (all_data && slot_free) begin
                        word       <= s1;
                        word_valid <= 1'b1;
                        word_count <= word_count + CNT_W'(1);
                        state      <= WAIT_NULL;
                        ack        <= 1'b1;
                    end
                end
                WAIT_NULL: begin
                    if (all_null) begin
                        state <= WAIT_DATA;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_DATA;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_dual_rail_rx.sv
// Directed bench for ncl_dual_rail_rx. It uses a 4-bit word counter so that the counter
// wrap (2^CNT_W + 1 handshakes) stays short.
module tb_ncl_dual_rail_rx;

    localparam int DIGITS = 32;
    localparam int SYNC   = 2;
    localparam int CNT_W  = 4;
    localparam int LAT    = SYNC + 1;

    logic              clk = 1'b0;
    logic              init_n;
    logic [DIGITS-1:0] rail1;
    logic [DIGITS-1:0] rail0;
    logic              ack;
    logic [DIGITS-1:0] word;
    logic              word_valid;
    logic              word_ready;
    logic              err_illegal;
    logic [CNT_W-1:0]  word_count;

    int checks = 0;
    int errors = 0;

    ncl_dual_rail_rx #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .init_n(init_n),
        .rail1(rail1),
        .rail0(rail0),
        .ack(ack),
        .word(word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .err_illegal(err_illegal),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_data(input logic [31:0] w);
        rail1 = w;
        rail0 = ~w;
    endtask

    task automatic drive_null();
        rail1 = '0;
        rail0 = '0;
    endtask

    task automatic wait_ack(input string tag, input logic val);
        int n;
        n = 0;
        while (ack !== val && n < 12) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(ack), 64'(val));
    endtask

    task automatic handshake(input logic [31:0] w);
        drive_data(w);
        wait_ack("hs_ack_rise", 1'b1);
        chk("hs_word", 64'(word), 64'(w));
        drive_null();
        wait_ack("hs_ack_fall", 1'b0);
    endtask

    initial begin
        logic seen;
        logic [31:0] w;

        init_n     = 1'b0;
        word_ready = 1'b1;
        drive_null();
        tick(3);
        init_n = 1'b1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_word", 64'(word), 64'd0);
        chk("rst_valid", 64'(word_valid), 64'd0);
        chk("rst_err", 64'(err_illegal), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);

        // Basic word: capture exactly LAT edges after the rails change.
        drive_data(32'h0000002A);
        tick(LAT - 1);
        chk("basic_early_ack", 64'(ack), 64'd0);
        tick(1);
        chk("basic_word", 64'(word), 64'h2A);
        chk("basic_valid", 64'(word_valid), 64'd1);
        chk("basic_ack", 64'(ack), 64'd1);
        chk("basic_count", 64'(word_count), 64'd1);
        drive_null();
        tick(LAT - 1);
        chk("null_early_ack", 64'(ack), 64'd1);
        tick(1);
        chk("null_ack", 64'(ack), 64'd0);

        // 31 of 32 digits complete: nothing may happen.
        w = 32'h12345678;
        rail1 = w & 32'h7FFFFFFF;
        rail0 = ~w & 32'h7FFFFFFF;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ack || word_valid) seen = 1'b1;
        end
        chk("partial_no_capture", 64'(seen), 64'd0);
        rail0[31] = 1'b1;
        tick(LAT);
        chk("partial_word", 64'(word), 64'h12345678);
        chk("partial_ack", 64'(ack), 64'd1);
        chk("partial_count", 64'(word_count), 64'd2);
        drive_null();
        tick(LAT);
        chk("partial_null_ack", 64'(ack), 64'd0);

        // Backpressure.
        word_ready = 1'b0;
        drive_data(32'h00000001);
        tick(LAT);
        chk("bp_word1", 64'(word), 64'h1);
        chk("bp_ack1", 64'(ack), 64'd1);
        drive_null();
        tick(LAT);
        chk("bp_null_ack", 64'(ack), 64'd0);
        drive_data(32'hFFFFFFFF);
        tick(LAT + 3);
        chk("bp_stall_ack", 64'(ack), 64'd0);
        chk("bp_stall_word", 64'(word), 64'h1);
        chk("bp_stall_valid", 64'(word_valid), 64'd1);
        chk("bp_stall_count", 64'(word_count), 64'd3);
        word_ready = 1'b1;
        tick(1);
        word_ready = 1'b0;
        chk("bp_swap_word", 64'(word), 64'hFFFFFFFF);
        chk("bp_swap_valid", 64'(word_valid), 64'd1);
        chk("bp_swap_ack", 64'(ack), 64'd1);
        chk("bp_swap_count", 64'(word_count), 64'd4);
        drive_null();
        tick(LAT);
        chk("bp_hold_valid", 64'(word_valid), 64'd1);
        chk("bp_null2_ack", 64'(ack), 64'd0);
        word_ready = 1'b1;
        tick(1);
        chk("bp_consume_valid", 64'(word_valid), 64'd0);

        // Illegal digit 5.
        rail1[5] = 1'b1;
        rail0[5] = 1'b1;
        tick(LAT);
        chk("ill_err", 64'(err_illegal), 64'd1);
        chk("ill_ack", 64'(ack), 64'd0);
        chk("ill_valid", 64'(word_valid), 64'd0);
        chk("ill_count", 64'(word_count), 64'd4);
        drive_null();
        tick(LAT);
        chk("ill_sticky", 64'(err_illegal), 64'd1);

        // Reset while waiting for NULL, then recapture of the held DATA.
        drive_data(32'hCAFE0001);
        tick(LAT);
        chk("mid_ack", 64'(ack), 64'd1);
        chk("mid_count", 64'(word_count), 64'd5);
        init_n = 1'b0;
        tick(1);
        init_n = 1'b1;
        chk("mid_rst_ack", 64'(ack), 64'd0);
        chk("mid_rst_word", 64'(word), 64'd0);
        chk("mid_rst_valid", 64'(word_valid), 64'd0);
        chk("mid_rst_count", 64'(word_count), 64'd0);
        chk("mid_rst_err", 64'(err_illegal), 64'd0);
        tick(LAT);
        chk("recap_word", 64'(word), 64'hCAFE0001);
        chk("recap_valid", 64'(word_valid), 64'd1);
        chk("recap_count", 64'(word_count), 64'd1);
        drive_null();
        wait_ack("recap_null_ack", 1'b0);

        // Counter wrap: 2^CNT_W + 1 handshakes from zero end at one.
        init_n = 1'b0;
        tick(1);
        init_n = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 1; i++)
            handshake(32'h9E3779B9 ^ (32'(i) * 32'h01010101));
        chk("wrap_count", 64'(word_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
